// File: rtl/fine_delay_pkg.sv
// Shared definitions for the fine delay scheduler: FSM encoding and the
// default width of the delay setting.
package fine_delay_pkg;

  localparam int LOG2_MAX_DELAY_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fine_delay_scheduler_counter.sv
// Counts sample strobes while the delay line refills; hit flags the strobe
// that brings the count up to the terminal value.
module valid_strobe_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             strobe,
  input  logic [WIDTH-1:0] terminal,
  output logic             hit
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  assign count_next = count_reg + WIDTH'(1);
  assign hit        = strobe && !clear && (count_next == terminal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (strobe) begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/fine_delay_scheduler.sv
// Schedules changes of a fine delay line setting, either as a single jump
// followed by a blanked refill period, or as a one-step-per-sample ramp.
module fine_delay_scheduler
  import fine_delay_pkg::*;
#(
  parameter int LOG2_MAX_DELAY = LOG2_MAX_DELAY_DEFAULT,
  parameter int STROBE_DIV     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  input  logic [LOG2_MAX_DELAY-1:0] req_delay_i,
  input  logic                      req_ramp_i,
  output logic                      req_ready_o,
  input  logic                      data_valid_i,
  output logic [LOG2_MAX_DELAY-1:0] delay_o,
  output logic                      blank_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int CW = LOG2_MAX_DELAY + 1;
  localparam logic [LOG2_MAX_DELAY-1:0] ONE = LOG2_MAX_DELAY'(1);

  fsm_state_t                state_reg;
  logic [LOG2_MAX_DELAY-1:0] target_reg;
  logic                      ramp_reg;
  logic [LOG2_MAX_DELAY-1:0] ramp_next;
  logic [CW-1:0]             settle_terminal;
  logic                      settle_clear;
  logic                      settle_hit;

  // Strobe timing is owned by the sample source; this block only reacts to data_valid_i.
  if (STROBE_DIV < 1) begin : g_strobe_div_unused
  end

  // One extra counter bit so a maximum target still yields a representable target+1.
  assign settle_terminal = {1'b0, target_reg} + CW'(1);
  assign settle_clear    = (state_reg != SETTLE);

  // Ramping only happens while delay_o differs from the target, so neither bound can wrap.
  always_comb begin
    ramp_next = delay_o;
    if (target_reg > delay_o) begin
      ramp_next = delay_o + ONE;
    end else if (target_reg < delay_o) begin
      ramp_next = delay_o - ONE;
    end
  end

  valid_strobe_counter #(
    .WIDTH (CW)
  ) u_settle_counter (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (settle_clear),
    .strobe   (data_valid_i),
    .terminal (settle_terminal),
    .hit      (settle_hit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      target_reg  <= '0;
      ramp_reg    <= 1'b0;
      delay_o     <= '0;
      blank_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      req_ready_o <= 1'b1;
    end else begin
      // Completion is announced the cycle after DONE is occupied.
      done_o <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            target_reg  <= req_delay_i;
            ramp_reg    <= req_ramp_i;
            req_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state_reg   <= (req_delay_i == delay_o) ? DONE : APPLY;
          end
        end
        APPLY: begin
          if (data_valid_i) begin
            if (ramp_reg) begin
              delay_o <= ramp_next;
              if (ramp_next == target_reg) begin
                state_reg <= DONE;
              end
            end else begin
              delay_o   <= target_reg;
              blank_o   <= 1'b1;
              state_reg <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (settle_hit) begin
            blank_o   <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy_o      <= 1'b0;
          req_ready_o <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fine_delay_scheduler.sv
// Directed bench for fine_delay_scheduler: a thread-style reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_fine_delay_scheduler;

  localparam int LW = 5;
  localparam int SD = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic [LW-1:0] req_delay_i = '0;
  logic          req_ramp_i = 1'b0;
  logic          req_ready_o;
  logic          data_valid_i = 1'b0;
  logic [LW-1:0] delay_o;
  logic          blank_o;
  logic          busy_o;
  logic          done_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit started = 0;

  int m_delay;
  bit m_blank, m_busy, m_done, m_ready;

  fine_delay_scheduler #(
    .LOG2_MAX_DELAY (LW),
    .STROBE_DIV     (SD)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_delay_i  (req_delay_i),
    .req_ramp_i   (req_ramp_i),
    .req_ready_o  (req_ready_o),
    .data_valid_i (data_valid_i),
    .delay_o      (delay_o),
    .blank_o      (blank_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every posedge of the run passes through here, so the strobe pattern never skips.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
    data_valid_i = (cyc % SD == 0);
  endtask

  // ---------------- reference model ----------------
  task automatic reset_model();
    m_delay = 0; m_blank = 0; m_busy = 0; m_done = 0; m_ready = 1;
  endtask

  task automatic step(output bit ab);
    @(posedge clk_i);
    m_done = 0;
    ab = rst_i;
    if (ab) reset_model();
  endtask

  initial begin
    bit ab;
    int tgt;
    int n;
    bit rmp;
    reset_model();
    forever begin
      step(ab);
      if (ab) continue;
      if (!(req_valid_i && m_ready)) continue;
      tgt = int'(req_delay_i);
      rmp = req_ramp_i;
      m_ready = 0;
      m_busy = 1;
      if (tgt != m_delay && !rmp) begin
        // Wait for the first strobe after acceptance, then blank for target+1 strobes.
        do step(ab); while (!ab && !data_valid_i);
        if (ab) continue;
        m_delay = tgt;
        m_blank = 1;
        n = 0;
        while (!ab && n < tgt + 1) begin
          step(ab);
          if (!ab && data_valid_i) n++;
        end
        if (ab) continue;
        m_blank = 0;
      end else if (tgt != m_delay) begin
        while (!ab && m_delay != tgt) begin
          step(ab);
          if (!ab && data_valid_i) m_delay += (tgt > m_delay) ? 1 : -1;
        end
        if (ab) continue;
      end
      // One cycle in DONE, then the pulse appears as the block returns to idle.
      step(ab);
      if (ab) continue;
      m_done = 1;
      m_busy = 0;
      m_ready = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk_i);
    if (started && !rst_i) begin
      n_vec++;
      if (delay_o !== LW'(m_delay) || blank_o !== m_blank || busy_o !== m_busy ||
          done_o !== m_done || req_ready_o !== m_ready) begin
        n_err++;
        $display("FAIL cycle_compare t=%0t: dut delay=%0d blank=%b busy=%b done=%b ready=%b, model delay=%0d blank=%b busy=%b done=%b ready=%b",
                 $time, delay_o, blank_o, busy_o, done_o, req_ready_o,
                 m_delay, m_blank, m_busy, m_done, m_ready);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic request(input int d, input bit r, input bit align);
    int g = 0;
    while (g < 100 && !(req_ready_o && (!align || data_valid_i))) begin
      tick();
      g++;
    end
    if (g >= 100) check("request_timeout", 0, 1);
    req_valid_i = 1;
    req_delay_i = LW'(d);
    req_ramp_i  = r;
    $display("request delay=%0d ramp=%0d strobe_coincident=%0d t=%0t", d, r, data_valid_i, $time);
    tick();
    req_valid_i = 0;
  endtask

  task automatic watch(input bit poke, output int bs, output int dn);
    bit poked = 0;
    bit seen = 0;
    bs = 0;
    dn = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      tick();
      req_valid_i = 0;
      @(negedge clk_i);
      if (blank_o && data_valid_i) bs++;
      if (done_o) begin
        dn++;
        seen = 1;
      end else if (poke && blank_o && !poked) begin
        poked = 1;
        check("ready_low_in_settle", int'(req_ready_o), 0);
        req_valid_i = 1;
        req_delay_i = LW'(5);
        req_ramp_i  = 0;
      end
    end
    if (!seen) check("watch_timeout", 0, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int bs, dn;
    int prev, t3, td, k, s;
    bit blank_seen, ch;
    int ramp_seen[$];
    int exp_ramp[4] = '{6, 5, 4, 3};

    repeat (3) tick();
    @(negedge clk_i);
    check("rst_delay", int'(delay_o), 0);
    check("rst_blank", int'(blank_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_ready", int'(req_ready_o), 1);
    tick();
    rst_i = 0;
    started = 1;
    repeat (2) tick();

    // Request equal to the current delay: done two cycles after acceptance.
    request(0, 0, 0);
    @(negedge clk_i);
    check("same_busy_c1", int'(busy_o), 1);
    check("same_done_c1", int'(done_o), 0);
    tick();
    @(negedge clk_i);
    check("same_done_c2", int'(done_o), 1);
    check("same_delay", int'(delay_o), 0);
    check("same_blank", int'(blank_o), 0);

    // Jump 0 -> 7: eight blanked strobes, one done pulse.
    request(7, 0, 0);
    watch(0, bs, dn);
    check("jump7_blank_strobes", bs, 8);
    check("jump7_done_pulses", dn, 1);
    check("jump7_delay", int'(delay_o), 7);

    // Ramp 7 -> 3: 6,5,4,3 without blanking, done one cycle after reaching 3.
    request(3, 1, 0);
    prev = 7; t3 = -1; td = -1; blank_seen = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      @(negedge clk_i);
      if (int'(delay_o) != prev) begin
        ramp_seen.push_back(int'(delay_o));
        prev = int'(delay_o);
        if (delay_o == 3) t3 = c;
      end
      if (blank_o) blank_seen = 1;
      if (done_o) begin
        td = c;
        break;
      end
    end
    check("ramp_steps", ramp_seen.size(), 4);
    for (int i = 0; i < 4 && i < ramp_seen.size(); i++) check("ramp_value", ramp_seen[i], exp_ramp[i]);
    check("ramp_blank_seen", int'(blank_seen), 0);
    check("ramp_done_lag", td - t3, 1);

    // Jump to the maximum: 32 blanked strobes, request during SETTLE ignored.
    request(31, 0, 0);
    watch(1, bs, dn);
    check("jump31_blank_strobes", bs, 32);
    check("jump31_done_pulses", dn, 1);
    check("jump31_delay", int'(delay_o), 31);
    repeat (6) tick();

    // Acceptance on a strobe cycle: delay_o holds until the following strobe.
    request(10, 0, 1);
    k = 0; ch = 0;
    for (int c = 0; c < 12 && !ch; c++) begin
      @(negedge clk_i);
      if (delay_o != 31) ch = 1;
      else k++;
      tick();
    end
    check("coincident_hold_cycles", k, 4);
    watch(0, bs, dn);
    check("coincident_done_pulses", dn, 1);
    check("coincident_delay", int'(delay_o), 10);

    // Reset in the middle of SETTLE.
    request(20, 0, 0);
    s = 0;
    for (int c = 0; c < 200 && s < 3; c++) begin
      tick();
      @(negedge clk_i);
      if (blank_o && data_valid_i) s++;
    end
    check("pre_reset_blank", int'(blank_o), 1);
    tick();
    rst_i = 1;
    #1;
    check("async_rst_delay", int'(delay_o), 0);
    check("async_rst_blank", int'(blank_o), 0);
    check("async_rst_busy", int'(busy_o), 0);
    check("async_rst_ready", int'(req_ready_o), 1);
    tick();
    @(negedge clk_i);
    check("rst_no_done", int'(done_o), 0);
    tick();
    rst_i = 0;
    request(2, 1, 0);
    watch(0, bs, dn);
    check("post_rst_done_pulses", dn, 1);
    check("post_rst_delay", int'(delay_o), 2);
    check("post_rst_blank_strobes", bs, 0);

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
